autosoc_soc_top: RTL and testbench



---
 rtl/autosoc_soc_top.sv | 263 ++++++++++++++++++++++++++
 tb/tb_autosoc_soc_top.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/autosoc_soc_top.sv
// rtl/autosoc_soc_top.sv - AutoSoC integration shell: reset stretcher, word memory, JTAG debug port
//
// autosoc_soc_top ports:
//   wb_clk_i        in   system clock (only clock)
//   wb_rst_i        in   synchronous active-high reset
//   tms_pad_i       in   JTAG TMS
//   tck_pad_i       in   JTAG TCK, oversampled as data
//   tdi_pad_i       in   JTAG TDI
//   tdo_pad_o       out  JTAG TDO, registered on detected TCK fall
//   uart_stx        out  UART transmit, idle high
//   uart_srx        in   UART receive, unused
//   can_rx_i        in   CAN receive, unused
//   can_tx_o        out  CAN transmit, recessive high
//   can_bus_off_on  out  CAN bus-off flag, low

module autosoc_ram #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);
  // Contents are deliberately never reset; the bench preloads them directly.
  reg [31:0] mem [0:DEPTH-1];

  always_ff @(posedge i_clk) begin
    if (i_we) mem[i_addr] <= i_wdata;
  end

  assign o_rdata = mem[i_addr];
endmodule

module autosoc_mem_ecc #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);
  autosoc_ram #(.DEPTH(DEPTH), .AW(AW)) ram0 (
    .i_clk   (i_clk),
    .i_we    (i_we),
    .i_addr  (i_addr),
    .i_wdata (i_wdata),
    .o_rdata (o_rdata)
  );
endmodule

module autosoc_wb_bfm_memory #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);
  autosoc_mem_ecc #(.DEPTH(DEPTH), .AW(AW)) memECC (
    .i_clk   (i_clk),
    .i_we    (i_we),
    .i_addr  (i_addr),
    .i_wdata (i_wdata),
    .o_rdata (o_rdata)
  );
endmodule

module autosoc_soc_top #(
  parameter int unsigned MEM_SIZE          = 32'h02000000,
  parameter logic [31:0] OPTION_CPU        = 32'd0,
  parameter logic [31:0] OPTION_PARITY     = 32'd0,
  parameter logic [31:0] OPTION_CHECKPOINT = 32'd0,
  parameter logic [31:0] OPTION_MEMECC     = 32'd0
) (
  input  logic wb_clk_i,
  input  logic wb_rst_i,
  input  logic tms_pad_i,
  input  logic tck_pad_i,
  input  logic tdi_pad_i,
  output logic tdo_pad_o,
  output logic uart_stx,
  input  logic uart_srx,
  input  logic can_rx_i,
  output logic can_tx_o,
  output logic can_bus_off_on
);
  localparam int unsigned DEPTH = MEM_SIZE / 4;
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [31:0] IDCODE_VAL  = 32'h149511C3;
  localparam logic [31:0] CONFIG_VAL  = {OPTION_CPU[7:0], OPTION_PARITY[7:0],
                                         OPTION_CHECKPOINT[7:0], OPTION_MEMECC[7:0]};
  localparam logic [3:0]  IR_IDCODE   = 4'h1;
  localparam logic [3:0]  IR_CONFIG   = 4'h2;
  localparam logic [3:0]  IR_MEMACC   = 4'h8;

  typedef enum logic [3:0] {
    TAP_TLR, TAP_RTI,
    TAP_SEL_DR, TAP_CAP_DR, TAP_SHIFT_DR, TAP_EXIT1_DR, TAP_PAUSE_DR, TAP_EXIT2_DR, TAP_UPD_DR,
    TAP_SEL_IR, TAP_CAP_IR, TAP_SHIFT_IR, TAP_EXIT1_IR, TAP_PAUSE_IR, TAP_EXIT2_IR, TAP_UPD_IR
  } tap_state_t;

  // Stretched system reset: held for 16 cycles after wb_rst_i drops.
  logic       wb_rst;
  logic [4:0] r_rst_cnt;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i)               r_rst_cnt <= 5'd16;
    else if (r_rst_cnt != 5'd0) r_rst_cnt <= r_rst_cnt - 5'd1;
  end

  assign wb_rst = wb_rst_i | (r_rst_cnt != 5'd0);

  // Pad synchronizers and TCK edge detection.
  logic [1:0] r_tck_sync, r_tms_sync, r_tdi_sync;
  logic       r_tck_prev;
  logic       w_tck_rise, w_tck_fall, w_tms, w_tdi;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst) begin
      r_tck_sync <= 2'b00;
      r_tms_sync <= 2'b00;
      r_tdi_sync <= 2'b00;
      r_tck_prev <= 1'b0;
    end else begin
      r_tck_sync <= {r_tck_sync[0], tck_pad_i};
      r_tms_sync <= {r_tms_sync[0], tms_pad_i};
      r_tdi_sync <= {r_tdi_sync[0], tdi_pad_i};
      r_tck_prev <= r_tck_sync[1];
    end
  end

  assign w_tck_rise = r_tck_sync[1] & ~r_tck_prev;
  assign w_tck_fall = ~r_tck_sync[1] & r_tck_prev;
  assign w_tms      = r_tms_sync[1];
  assign w_tdi      = r_tdi_sync[1];

  // TAP controller.
  tap_state_t r_tap, w_tap_next;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst) r_tap <= TAP_TLR;
    else        r_tap <= w_tap_next;
  end

  always_comb begin
    w_tap_next = r_tap;
    if (w_tck_rise) begin
      case (r_tap)
        TAP_TLR:      w_tap_next = w_tms ? TAP_TLR      : TAP_RTI;
        TAP_RTI:      w_tap_next = w_tms ? TAP_SEL_DR   : TAP_RTI;
        TAP_SEL_DR:   w_tap_next = w_tms ? TAP_SEL_IR   : TAP_CAP_DR;
        TAP_CAP_DR:   w_tap_next = w_tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
        TAP_SHIFT_DR: w_tap_next = w_tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
        TAP_EXIT1_DR: w_tap_next = w_tms ? TAP_UPD_DR   : TAP_PAUSE_DR;
        TAP_PAUSE_DR: w_tap_next = w_tms ? TAP_EXIT2_DR : TAP_PAUSE_DR;
        TAP_EXIT2_DR: w_tap_next = w_tms ? TAP_UPD_DR   : TAP_SHIFT_DR;
        TAP_UPD_DR:   w_tap_next = w_tms ? TAP_SEL_DR   : TAP_RTI;
        TAP_SEL_IR:   w_tap_next = w_tms ? TAP_TLR      : TAP_CAP_IR;
        TAP_CAP_IR:   w_tap_next = w_tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
        TAP_SHIFT_IR: w_tap_next = w_tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
        TAP_EXIT1_IR: w_tap_next = w_tms ? TAP_UPD_IR   : TAP_PAUSE_IR;
        TAP_PAUSE_IR: w_tap_next = w_tms ? TAP_EXIT2_IR : TAP_PAUSE_IR;
        TAP_EXIT2_IR: w_tap_next = w_tms ? TAP_UPD_IR   : TAP_SHIFT_IR;
        TAP_UPD_IR:   w_tap_next = w_tms ? TAP_SEL_DR   : TAP_RTI;
        default:      w_tap_next = TAP_TLR;
      endcase
    end
  end

  // Instruction and data registers. One 65-bit DR serves every instruction;
  // shorter registers occupy its low bits and take TDI at their own MSB.
  logic [3:0]  r_ir, r_ir_sr;
  logic [64:0] r_dr, w_dr_capture, w_dr_shifted;
  logic [31:0] r_rdata, r_last_addr;
  logic        r_tdo;

  logic [31:0] w_addr, w_ram_rdata;
  logic [29:0] w_word;
  logic        w_in_range, w_dr_wr, w_upd_dr, w_mem_we;

  assign w_dr_wr    = r_dr[64];
  assign w_addr     = r_dr[63:32];
  assign w_word     = w_addr[31:2];
  assign w_in_range = {2'b00, w_word} < DEPTH;
  // Update actions fire on the rise that enters Update-DR, not while sitting in it.
  assign w_upd_dr   = w_tck_rise && (w_tap_next == TAP_UPD_DR) && (r_ir == IR_MEMACC);
  assign w_mem_we   = w_upd_dr && w_dr_wr && w_in_range && !wb_rst;

  always_comb begin
    w_dr_capture = 65'd0;
    w_dr_shifted = {64'd0, w_tdi};
    case (r_ir)
      IR_IDCODE: begin
        w_dr_capture = {33'd0, IDCODE_VAL};
        w_dr_shifted = {33'd0, w_tdi, r_dr[31:1]};
      end
      IR_CONFIG: begin
        w_dr_capture = {33'd0, CONFIG_VAL};
        w_dr_shifted = {33'd0, w_tdi, r_dr[31:1]};
      end
      IR_MEMACC: begin
        w_dr_capture = {1'b0, r_last_addr, r_rdata};
        w_dr_shifted = {w_tdi, r_dr[64:1]};
      end
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst) begin
      r_ir        <= IR_IDCODE;
      r_ir_sr     <= 4'd0;
      r_dr        <= 65'd0;
      r_rdata     <= 32'd0;
      r_last_addr <= 32'd0;
      r_tdo       <= 1'b0;
    end else begin
      if (r_tap == TAP_TLR) r_ir <= IR_IDCODE;
      if (w_tck_rise) begin
        case (r_tap)
          TAP_CAP_IR:   r_ir_sr <= 4'b0001;
          TAP_SHIFT_IR: r_ir_sr <= {w_tdi, r_ir_sr[3:1]};
          TAP_CAP_DR:   r_dr    <= w_dr_capture;
          TAP_SHIFT_DR: r_dr    <= w_dr_shifted;
          default: ;
        endcase
        if (w_tap_next == TAP_UPD_IR) r_ir <= r_ir_sr;
      end
      if (w_upd_dr) begin
        r_last_addr <= w_addr;
        if (!w_dr_wr) r_rdata <= w_in_range ? w_ram_rdata : 32'd0;
      end
      if (w_tck_fall) begin
        if (r_tap == TAP_SHIFT_IR)      r_tdo <= r_ir_sr[0];
        else if (r_tap == TAP_SHIFT_DR) r_tdo <= r_dr[0];
        else                            r_tdo <= 1'b0;
      end
    end
  end

  autosoc_wb_bfm_memory #(.DEPTH(DEPTH), .AW(AW)) wb_bfm_memory0 (
    .i_clk   (wb_clk_i),
    .i_we    (w_mem_we),
    .i_addr  (w_addr[AW+1:2]),
    .i_wdata (r_dr[31:0]),
    .o_rdata (w_ram_rdata)
  );

  assign tdo_pad_o      = r_tdo;
  assign uart_stx       = 1'b1;
  assign can_tx_o       = 1'b1;
  assign can_bus_off_on = 1'b0;

  logic w_unused;
  assign w_unused = &{1'b0, uart_srx, can_rx_i, w_addr[1:0]};
endmodule

// File: tb/tb_autosoc_soc_top.sv
// tb/tb_autosoc_soc_top.sv - randomized JTAG bench for autosoc_soc_top against a memory/register model
module tb_autosoc_soc_top;
  localparam int unsigned MEM_BYTES = 32'h400;
  localparam int unsigned WORDS     = MEM_BYTES / 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tms = 1'b1, tck = 1'b0, tdi = 1'b0, srx = 1'b1, canrx = 1'b1;
  logic tdo, stx, cantx, busoff;

  always #5 clk = ~clk;

  autosoc_soc_top #(
    .MEM_SIZE(MEM_BYTES), .OPTION_CPU(32'd1), .OPTION_PARITY(32'd2),
    .OPTION_CHECKPOINT(32'd3), .OPTION_MEMECC(32'd4)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .tms_pad_i(tms), .tck_pad_i(tck), .tdi_pad_i(tdi),
    .tdo_pad_o(tdo), .uart_stx(stx), .uart_srx(srx), .can_rx_i(canrx),
    .can_tx_o(cantx), .can_bus_off_on(busoff)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] model_mem [WORDS];
  logic [31:0] m_rdata = 32'd0;
  logic [31:0] m_last  = 32'd0;

  task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One TCK period; TDO is sampled just before the rise.
  task automatic tck_cycle(input logic t_ms, input logic t_di, output logic t_do);
    @(negedge clk);
    tms = t_ms;
    tdi = t_di;
    repeat (5) @(negedge clk);
    t_do = tdo;
    tck = 1'b1;
    repeat (5) @(negedge clk);
    tck = 1'b0;
  endtask

  task automatic tap_reset();
    logic d;
    repeat (5) tck_cycle(1'b1, 1'b0, d);
    tck_cycle(1'b0, 1'b0, d);
  endtask

  // From Run-Test-Idle back to Run-Test-Idle.
  task automatic shift_ir(input logic [3:0] code, output logic [3:0] cap);
    logic d;
    tck_cycle(1'b1, 1'b0, d);
    tck_cycle(1'b1, 1'b0, d);
    tck_cycle(1'b0, 1'b0, d);
    tck_cycle(1'b0, 1'b0, d);
    for (int i = 0; i < 4; i++) begin
      tck_cycle(i == 3, code[i], d);
      cap[i] = d;
    end
    tck_cycle(1'b1, 1'b0, d);
    tck_cycle(1'b0, 1'b0, d);
  endtask

  task automatic shift_dr(input int len, input logic [64:0] din, output logic [64:0] dout);
    logic d;
    dout = 65'd0;
    tck_cycle(1'b1, 1'b0, d);
    tck_cycle(1'b0, 1'b0, d);
    tck_cycle(1'b0, 1'b0, d);
    for (int i = 0; i < len; i++) begin
      tck_cycle(i == len - 1, din[i], d);
      dout[i] = d;
    end
    tck_cycle(1'b1, 1'b0, d);
    tck_cycle(1'b0, 1'b0, d);
  endtask

  // MEMACC transaction: checks what Capture-DR reported, then advances the model.
  task automatic memacc(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                        output logic [64:0] cap);
    logic in_range;
    shift_dr(65, {wr, addr, data}, cap);
    check("memacc_capture", cap, {1'b0, m_last, m_rdata});
    in_range = (addr / 4) < WORDS;
    m_last = addr;
    if (wr) begin
      if (in_range) model_mem[addr / 4] = data;
    end else begin
      m_rdata = in_range ? model_mem[addr / 4] : 32'd0;
    end
  endtask

  task automatic check_mem(input string tag);
    int diffs = 0;
    for (int i = 0; i < WORDS; i++)
      if (dut.wb_bfm_memory0.memECC.ram0.mem[i] !== model_mem[i]) diffs++;
    check(tag, diffs, 0);
  endtask

  initial begin
    logic [3:0]  cap_ir;
    logic [64:0] out;
    logic [31:0] v;
    logic        d;
    int          stretch;

    for (int i = 0; i < WORDS; i++) begin
      v = $urandom;
      model_mem[i] = v;
      dut.wb_bfm_memory0.memECC.ram0.mem[i] = v;
    end

    // Reset values and stretched reset length.
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_tdo", tdo, 0);
    check("rst_uart_stx", stx, 1);
    check("rst_can_tx", cantx, 1);
    check("rst_bus_off", busoff, 0);
    rst = 1'b0;
    stretch = 0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (dut.wb_rst) stretch++;
      @(negedge clk);
    end
    check("rst_stretch_cycles", stretch, 16);

    // IDCODE selected out of Test-Logic-Reset.
    tap_reset();
    shift_dr(32, 65'd0, out);
    check("idcode", out[31:0], 32'h149511C3);

    // BYPASS: leading 0 then TDI delayed by one bit.
    shift_ir(4'hF, cap_ir);
    check("ir_capture", cap_ir, 4'b0001);
    shift_dr(4, 65'b1101, out);
    check("bypass", out[3:0], 4'b1010);

    // CONFIG word from the option parameters.
    shift_ir(4'h2, cap_ir);
    shift_dr(32, 65'd0, out);
    check("config", out[31:0], 32'h01020304);

    // Backdoor preload, MEMACC read, value shows at next capture.
    shift_ir(4'h8, cap_ir);
    model_mem[5] = 32'hDEADBEEF;
    dut.wb_bfm_memory0.memECC.ram0.mem[5] = 32'hDEADBEEF;
    memacc(1'b0, 32'h14, 32'h0, out);
    memacc(1'b0, 32'h14, 32'h0, out);
    check("backdoor_read", out[31:0], 32'hDEADBEEF);

    // JTAG write, then an out-of-range write that must be dropped.
    memacc(1'b1, 32'h20, 32'hCAFEF00D, out);
    check("write_mem8", dut.wb_bfm_memory0.memECC.ram0.mem[8], 32'hCAFEF00D);
    memacc(1'b1, MEM_BYTES, 32'h12345678, out);
    check_mem("oob_write_dropped");

    // Random reads/writes, a slice of them out of range.
    for (int n = 0; n < 40; n++)
      memacc(1'($urandom_range(0, 1)), 32'($urandom_range(0, MEM_BYTES + 32'h7F)), $urandom, out);
    memacc(1'b0, 32'h0, 32'h0, out);
    check_mem("random_mem");

    // Reset in the middle of a MEMACC write shift.
    begin
      logic [64:0] din;
      din = {1'b1, 32'h30, 32'h5A5A5A5A};
      tck_cycle(1'b1, 1'b0, d);
      tck_cycle(1'b0, 1'b0, d);
      tck_cycle(1'b0, 1'b0, d);
      for (int i = 0; i < 40; i++) tck_cycle(1'b0, din[i], d);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("midshift_rst_tdo", tdo, 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    m_rdata = 32'd0;
    m_last  = 32'd0;
    check("midshift_mem12", dut.wb_bfm_memory0.memECC.ram0.mem[12], model_mem[12]);
    tck_cycle(1'b0, 1'b0, d);
    shift_dr(32, 65'd0, out);
    check("idcode_after_rst", out[31:0], 32'h149511C3);
    shift_ir(4'h8, cap_ir);
    memacc(1'b0, 32'h0, 32'h0, out);
    check_mem("final_mem");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
